// File: rtl/serial_arith_pkg.sv
// Shared encodings for the serial arithmetic leaves.
// FSM states and the busy decode used by their control logic.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic st_busy(input state_t s);
        return (s == ST_RUN) || (s == ST_DONE);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the serial subtractor.
// The master side presents operands and consumes the result.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_diff;
    logic             out_borrow;
    logic             busy;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_diff,
        input  out_borrow, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_diff,
        output out_borrow, busy
    );

endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
// Purely combinational bit cell of the serial datapath.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one bit per clock.
// Operands and result move over valid/ready handshakes.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic              clk,
    input logic              rst_n,
    serial_subtractor_if.slave bus
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] diff;
    logic [CW-1:0]    cnt;
    logic             bw;
    logic             bw_q;
    logic             ov;
    logic             d;
    logic             bout;

    full_subtractor u_fs (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (bw),
        .d    (d),
        .bout (bout)
    );

    assign bus.in_ready   = (state == ST_IDLE);
    assign bus.out_valid  = ov;
    assign bus.out_diff   = diff;
    assign bus.out_borrow = bw_q;
    assign bus.busy       = st_busy(state);

    // diff doubles as the result shift register; it only
    // moves in RUN, so it is stable in DONE and IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            diff  <= '0;
            cnt   <= '0;
            bw    <= 1'b0;
            bw_q  <= 1'b0;
            ov    <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_sr  <= bus.in_a;
                        b_sr  <= bus.in_b;
                        bw    <= 1'b0;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    diff <= {d, diff[WIDTH-1:1]};
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    bw   <= bout;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        bw_q  <= bout;
                        ov    <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        ov    <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    ov    <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=8 and WIDTH=4.
// Expected values are hand-computed or taken from a {b,d} model.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_subtractor_if #(.WIDTH(8)) b8 ();
    serial_subtractor_if #(.WIDTH(4)) b4 ();

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b8)
    );

    serial_subtractor #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b4)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h",
                     tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [7:0] a,
                          input logic [7:0] b,
                          input logic [7:0] ed,
                          input logic       eb,
                          input string      tag);
        int   n;
        logic irhi;
        b8.in_a     = a;
        b8.in_b     = b;
        b8.in_valid = 1'b1;
        b8.out_ready = 1'b0;
        tick();
        b8.in_valid = 1'b0;
        chk({tag, "_busy_run"}, b8.busy, 1);
        n = 0;
        irhi = 1'b0;
        while (!b8.out_valid && n < 40) begin
            if (b8.in_ready) irhi = 1'b1;
            tick();
            n++;
        end
        chk({tag, "_lat"}, n, 8);
        chk({tag, "_irlow"}, irhi, 0);
        chk({tag, "_diff"}, b8.out_diff, ed);
        chk({tag, "_bw"}, b8.out_borrow, eb);
        chk({tag, "_busy_done"}, b8.busy, 1);
    endtask

    task automatic take(input string tag);
        b8.out_ready = 1'b1;
        tick();
        b8.out_ready = 1'b0;
        chk({tag, "_ov_clr"}, b8.out_valid, 0);
        chk({tag, "_ir_back"}, b8.in_ready, 1);
        chk({tag, "_busy_clr"}, b8.busy, 0);
    endtask

    initial begin
        int hi;
        int n;
        int acc;
        int prev;
        logic seen;
        logic [7:0] cap;
        logic [3:0] ea;
        logic [3:0] eb4;
        logic [4:0] m;

        b8.in_valid  = 1'b0;
        b8.in_a      = '0;
        b8.in_b      = '0;
        b8.out_ready = 1'b0;
        b4.in_valid  = 1'b0;
        b4.in_a      = '0;
        b4.in_b      = '0;
        b4.out_ready = 1'b0;

        #1 rst_n = 1'b0;
        #2;
        chk("rst_ov", b8.out_valid, 0);
        chk("rst_diff", b8.out_diff, 0);
        chk("rst_bw", b8.out_borrow, 0);
        chk("rst_busy", b8.busy, 0);
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_ir", b8.in_ready, 1);

        run_op(8'h05, 8'h03, 8'h02, 1'b0, "t1");
        take("t1");
        run_op(8'h03, 8'h05, 8'hFE, 1'b1, "t2a");
        take("t2a");
        run_op(8'h00, 8'h01, 8'hFF, 1'b1, "t2b");
        take("t2b");
        run_op(8'hFF, 8'hFF, 8'h00, 1'b0, "t2c");
        take("t2c");

        run_op(8'h03, 8'h05, 8'hFE, 1'b1, "bp");
        b8.in_valid = 1'b1;
        b8.in_a     = 8'hAA;
        b8.in_b     = 8'h11;
        repeat (5) begin
            tick();
            chk("bp_ov", b8.out_valid, 1);
            chk("bp_diff", b8.out_diff, 8'hFE);
            chk("bp_bw", b8.out_borrow, 1);
            chk("bp_ir", b8.in_ready, 0);
        end
        b8.in_valid = 1'b0;
        take("bp");
        chk("bp_hold_diff", b8.out_diff, 8'hFE);

        b8.in_a     = 8'h80;
        b8.in_b     = 8'h01;
        b8.in_valid = 1'b1;
        tick();
        b8.in_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("ab_ov", b8.out_valid, 0);
        chk("ab_diff", b8.out_diff, 0);
        chk("ab_bw", b8.out_borrow, 0);
        chk("ab_busy", b8.busy, 0);
        tick();
        tick();
        rst_n = 1'b1;
        chk("ab_ir", b8.in_ready, 1);
        seen = 1'b0;
        repeat (12) begin
            tick();
            if (b8.out_valid) seen = 1'b1;
        end
        chk("ab_no_ov", seen, 0);
        run_op(8'h80, 8'h01, 8'h7F, 1'b0, "ab2");
        take("ab2");

        b8.out_ready = 1'b1;
        b8.in_a      = 8'h10;
        b8.in_b      = 8'h20;
        b8.in_valid  = 1'b1;
        tick();
        b8.in_valid = 1'b0;
        hi  = 0;
        cap = '0;
        repeat (14) begin
            tick();
            if (b8.out_valid) begin
                hi++;
                cap = b8.out_diff;
            end
        end
        b8.out_ready = 1'b0;
        chk("or_pulse", hi, 1);
        chk("or_diff", cap, 8'hF0);
        chk("or_bw", b8.out_borrow, 1);

        b4.in_valid  = 1'b1;
        b4.out_ready = 1'b1;
        prev = 0;
        for (int p = 0; p < 256; p++) begin
            ea  = 4'(p >> 4);
            eb4 = 4'(p);
            b4.in_a = ea;
            b4.in_b = eb4;
            n = 0;
            while (!b4.in_ready && n < 20) begin
                tick();
                n++;
            end
            tick();
            acc = cyc;
            if (p > 0) chk("w4_space", acc - prev, 6);
            prev = acc;
            n = 0;
            while (!b4.out_valid && n < 20) begin
                tick();
                n++;
            end
            m = {1'b0, ea} - {1'b0, eb4};
            chk("w4_lat", n, 4);
            chk("w4_diff", b4.out_diff, m[3:0]);
            chk("w4_bw", b4.out_borrow, m[4]);
        end
        b4.in_valid = 1'b0;
        tick();
        tick();
        chk("w4_idle", b4.in_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
